// File: rtl/dbuf_pingpong_ctrl.sv
// dbuf_pingpong_ctrl: ping-pong double buffer; producer fills the back bank, display reads the front bank,
// banks swap only when the back bank is full and the front bank sits at a pass boundary.
module dbuf_pingpong_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int LOOP_READ = 1
) (
  input  logic              clk_new,
  input  logic              resetn,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_en_i,
  output logic              rd_ready_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              buf_sel_o,
  output logic              swap_pulse_o,
  output logic [7:0]        frame_cnt_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, front_word;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic buf_sel_q, buf_sel_d, back_full_q, back_full_d, front_valid_q, front_valid_d;
  logic at_boundary_q, at_boundary_d, rd_valid_q, rd_valid_d, swap_pulse_q, swap_pulse_d;
  logic swap_now, wr_fire;
  assign wr_ready_o   = !back_full_q;
  assign swap_now     = back_full_q && (!front_valid_q || at_boundary_q);
  assign rd_ready_o   = front_valid_q && !swap_now && rd_en_i;
  assign wr_fire      = wr_valid_i && wr_ready_o;
  assign front_word   = buf_sel_q ? bank_a[rd_ptr_q] : bank_b[rd_ptr_q];
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_addr_o    = rd_addr_q;
  assign buf_sel_o    = buf_sel_q;
  assign swap_pulse_o = swap_pulse_q;
  assign frame_cnt_o  = frame_cnt_q;
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    buf_sel_d     = buf_sel_q;
    back_full_d   = back_full_q;
    front_valid_d = front_valid_q;
    at_boundary_d = at_boundary_q;
    frame_cnt_d   = frame_cnt_q;
    rd_valid_d    = rd_ready_o;
    swap_pulse_d  = swap_now;
    rd_data_d     = rd_ready_o ? front_word : rd_data_q;
    rd_addr_d     = rd_ready_o ? rd_ptr_q : rd_addr_q;
    if (swap_now) begin
      buf_sel_d     = !buf_sel_q;
      front_valid_d = 1'b1;
      back_full_d   = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      at_boundary_d = 1'b0;
      frame_cnt_d   = frame_cnt_q + 8'd1;
    end else begin
      if (wr_fire) begin
        wr_ptr_d    = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        back_full_d = (wr_ptr_q == LAST);
      end
      // boundary is raised by the last word and cleared by the next pass starting at address 0
      if (rd_ready_o) begin
        rd_ptr_d      = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        at_boundary_d = (rd_ptr_q == LAST) || (at_boundary_q && rd_ptr_q != '0);
        front_valid_d = !(LOOP_READ == 0 && rd_ptr_q == LAST);
      end
    end
  end
  always_ff @(posedge clk_new) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      buf_sel_q     <= 1'b0;
      back_full_q   <= 1'b0;
      front_valid_q <= 1'b0;
      at_boundary_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_addr_q     <= '0;
      swap_pulse_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_sel_q     <= buf_sel_d;
      back_full_q   <= back_full_d;
      front_valid_q <= front_valid_d;
      at_boundary_q <= at_boundary_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      rd_addr_q     <= rd_addr_d;
      swap_pulse_q  <= swap_pulse_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
  always_ff @(posedge clk_new) begin
    if (resetn && wr_fire && buf_sel_q) bank_b[wr_ptr_q] <= wr_data_i;
    if (resetn && wr_fire && !buf_sel_q) bank_a[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: tb/tb_dbuf_pingpong_ctrl.sv
// tb_dbuf_pingpong_ctrl: directed scenarios for the ping-pong buffer, looping and one-shot read variants.
module tb_dbuf_pingpong_ctrl;
  logic clk_new = 1'b0;
  logic resetn = 1'b0;
  logic wr_valid = 1'b0, rd_en = 1'b0, wr_ready, rd_ready, rd_valid, buf_sel, swap_pulse;
  logic [7:0] wr_data = '0, rd_data, frame_cnt;
  logic [4:0] rd_addr;
  logic w0_valid = 1'b0, r0_en = 1'b0, w0_ready, r0_ready, r0_valid, b0_sel, s0_pulse;
  logic [7:0] w0_data = '0, r0_data, f0_cnt;
  logic [4:0] r0_addr;
  int passed = 0, total = 0;

  always #5 clk_new = ~clk_new;

  dbuf_pingpong_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .LOOP_READ(1)) dut (
    .clk_new(clk_new), .resetn(resetn),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_en_i(rd_en), .rd_ready_o(rd_ready), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .rd_addr_o(rd_addr), .buf_sel_o(buf_sel),
    .swap_pulse_o(swap_pulse), .frame_cnt_o(frame_cnt)
  );

  dbuf_pingpong_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .LOOP_READ(0)) dut0 (
    .clk_new(clk_new), .resetn(resetn),
    .wr_valid_i(w0_valid), .wr_data_i(w0_data), .wr_ready_o(w0_ready),
    .rd_en_i(r0_en), .rd_ready_o(r0_ready), .rd_valid_o(r0_valid),
    .rd_data_o(r0_data), .rd_addr_o(r0_addr), .buf_sel_o(b0_sel),
    .swap_pulse_o(s0_pulse), .frame_cnt_o(f0_cnt)
  );

  task automatic tick;
    @(posedge clk_new);
    #1;
  endtask

  task automatic fill_main(input int base, input int step);
    logic ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(base + i * step);
      #1;
      if (wr_ready !== 1'b1) ok = 1'b0;
      tick;
    end
    wr_valid = 1'b0;
    total++;
    if (ok !== 1'b1) $display("FAIL fill_wr_ready: wr_ready dropped during 32-word fill (base %0d)", base);
    else passed++;
  endtask

  task automatic read_main(input int n, input int start, input int base);
    int a;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick;
      a = (start + i) % 32;
      total++;
      if ({rd_valid, rd_data, rd_addr, swap_pulse} !== {1'b1, 8'(base + a), 5'(a), 1'b0})
        $display("FAIL read_%0d: got valid=%b data=%0d addr=%0d swap=%b, want 1/%0d/%0d/0", i, rd_valid, rd_data, rd_addr, swap_pulse, base + a, a);
      else passed++;
    end
  endtask

  task automatic fill_l0(input int base);
    logic ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w0_valid = 1'b1;
      w0_data = 8'(base + i);
      #1;
      if (w0_ready !== 1'b1) ok = 1'b0;
      tick;
    end
    w0_valid = 1'b0;
    total++;
    if (ok !== 1'b1) $display("FAIL l0_fill_wr_ready: wr_ready dropped during fill (base %0d)", base);
    else passed++;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    total++;
    if ({buf_sel, frame_cnt, rd_valid, rd_data, rd_addr, swap_pulse, wr_ready} !== {1'b0, 8'd0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: sel=%b frame=%0d rv=%b rd=%0d ra=%0d swap=%b wr_ready=%b, want 0/0/0/0/0/0/1", buf_sel, frame_cnt, rd_valid, rd_data, rd_addr, swap_pulse, wr_ready);
    else passed++;
    rd_en = 1'b1;
    #1;
    total++;
    if (rd_ready !== 1'b0) $display("FAIL early_rd_ready: got %b want 0", rd_ready);
    else passed++;
    tick;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL early_rd_valid: got %b want 0", rd_valid);
    else passed++;
    rd_en = 1'b0;
  endtask

  task automatic test_first_frame;
    fill_main(0, 1);
    #1;
    total++;
    if ({wr_ready, buf_sel, swap_pulse} !== 3'b000)
      $display("FAIL full_before_swap: wr_ready=%b sel=%b swap=%b, want 0/0/0", wr_ready, buf_sel, swap_pulse);
    else passed++;
    tick;
    total++;
    if ({swap_pulse, buf_sel, frame_cnt, wr_ready} !== {1'b1, 1'b1, 8'd1, 1'b1})
      $display("FAIL first_swap: swap=%b sel=%b frame=%0d wr_ready=%b, want 1/1/1/1", swap_pulse, buf_sel, frame_cnt, wr_ready);
    else passed++;
    tick;
    total++;
    if (swap_pulse !== 1'b0) $display("FAIL swap_one_cycle: got %b want 0", swap_pulse);
    else passed++;
  endtask

  task automatic test_read_pass;
    read_main(32, 0, 0);
    rd_en = 1'b0;
  endtask

  task automatic test_loop_read;
    read_main(64, 0, 0);
    rd_en = 1'b0;
  endtask

  task automatic test_swap_at_boundary;
    logic ok = 1'b1;
    read_main(10, 0, 0);
    rd_en = 1'b0;
    fill_main(100, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      if ({swap_pulse, buf_sel} !== 2'b01) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) $display("FAIL early_swap: swapped while front mid-pass (swap=%b sel=%b)", swap_pulse, buf_sel);
    else passed++;
    read_main(22, 10, 0);
    #1;
    total++;
    if (rd_ready !== 1'b0) $display("FAIL swap_rd_ready: got %b want 0", rd_ready);
    else passed++;
    tick;
    total++;
    if ({swap_pulse, buf_sel, frame_cnt, rd_valid} !== {1'b1, 1'b0, 8'd2, 1'b0})
      $display("FAIL boundary_swap: swap=%b sel=%b frame=%0d rv=%b, want 1/0/2/0", swap_pulse, buf_sel, frame_cnt, rd_valid);
    else passed++;
    read_main(4, 0, 100);
    rd_en = 1'b0;
  endtask

  task automatic test_one_shot;
    fill_l0(0);
    tick;
    total++;
    if ({s0_pulse, f0_cnt, b0_sel} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL l0_first_swap: swap=%b frame=%0d sel=%b, want 1/1/1", s0_pulse, f0_cnt, b0_sel);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      r0_en = 1'b1;
      tick;
      total++;
      if ({r0_valid, r0_data, r0_addr} !== {1'b1, 8'(i), 5'(i)})
        $display("FAIL l0_read_%0d: got valid=%b data=%0d addr=%0d, want 1/%0d/%0d", i, r0_valid, r0_data, r0_addr, i, i);
      else passed++;
    end
    #1;
    total++;
    if (r0_ready !== 1'b0) $display("FAIL l0_33rd_rd_ready: got %b want 0", r0_ready);
    else passed++;
    tick;
    total++;
    if (r0_valid !== 1'b0) $display("FAIL l0_33rd_rd_valid: got %b want 0", r0_valid);
    else passed++;
    r0_en = 1'b0;
    fill_l0(50);
    tick;
    total++;
    if ({s0_pulse, f0_cnt, b0_sel} !== {1'b1, 8'd2, 1'b0})
      $display("FAIL l0_second_swap: swap=%b frame=%0d sel=%b, want 1/2/0", s0_pulse, f0_cnt, b0_sel);
    else passed++;
    r0_en = 1'b1;
    tick;
    r0_en = 1'b0;
    total++;
    if ({r0_valid, r0_data, r0_addr} !== {1'b1, 8'd50, 5'd0})
      $display("FAIL l0_new_frame_read: got valid=%b data=%0d addr=%0d, want 1/50/0", r0_valid, r0_data, r0_addr);
    else passed++;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(200 + i);
      tick;
    end
    wr_valid = 1'b0;
    read_main(5, 4, 100);
    rd_en = 1'b0;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    total++;
    if ({buf_sel, frame_cnt, rd_valid, rd_data, rd_addr, swap_pulse, wr_ready} !== {1'b0, 8'd0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b1})
      $display("FAIL midreset_state: sel=%b frame=%0d rv=%b rd=%0d ra=%0d swap=%b wr_ready=%b, want 0/0/0/0/0/0/1", buf_sel, frame_cnt, rd_valid, rd_data, rd_addr, swap_pulse, wr_ready);
    else passed++;
    for (int i = 0; i < 31; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i * 3);
      tick;
    end
    wr_valid = 1'b0;
    tick;
    total++;
    if ({swap_pulse, frame_cnt, wr_ready} !== {1'b0, 8'd0, 1'b1})
      $display("FAIL midreset_31_writes: swap=%b frame=%0d wr_ready=%b, want 0/0/1", swap_pulse, frame_cnt, wr_ready);
    else passed++;
    wr_valid = 1'b1;
    wr_data = 8'd93;
    tick;
    wr_valid = 1'b0;
    tick;
    total++;
    if ({swap_pulse, frame_cnt, buf_sel} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL midreset_swap: swap=%b frame=%0d sel=%b, want 1/1/1", swap_pulse, frame_cnt, buf_sel);
    else passed++;
    rd_en = 1'b1;
    tick;
    total++;
    if ({rd_valid, rd_data, rd_addr} !== {1'b1, 8'd0, 5'd0})
      $display("FAIL midreset_read0: got valid=%b data=%0d addr=%0d, want 1/0/0", rd_valid, rd_data, rd_addr);
    else passed++;
    tick;
    total++;
    if ({rd_valid, rd_data, rd_addr} !== {1'b1, 8'd3, 5'd1})
      $display("FAIL midreset_read1: got valid=%b data=%0d addr=%0d, want 1/3/1", rd_valid, rd_data, rd_addr);
    else passed++;
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int swaps = 0, cyc = 0, last_at = 0, gap = 0;
    wr_valid = 1'b1;
    rd_en = 1'b1;
    while (swaps < 255 && cyc < 255 * 40 + 100) begin
      wr_data = 8'(cyc);
      tick;
      cyc++;
      if (swap_pulse === 1'b1) begin
        swaps++;
        gap = cyc - last_at;
        last_at = cyc;
      end
    end
    wr_valid = 1'b0;
    rd_en = 1'b0;
    total++;
    if (swaps !== 255) $display("FAIL wrap_swap_count: got %0d swaps want 255 within bound", swaps);
    else passed++;
    total++;
    if (frame_cnt !== 8'd0) $display("FAIL frame_wrap: got %0d want 0", frame_cnt);
    else passed++;
    total++;
    if (gap !== 33) $display("FAIL streaming_period: got %0d cycles between swaps want 33", gap);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_read_pass;
    test_loop_read;
    test_swap_at_boundary;
    test_one_shot;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
